fifo_memory: RTL and testbench
==============================

Name: fifo_memory

Overview:
- Single-clock synchronous FIFO buffer: 32-bit data, 8 entries deep.
- Sits between a producer and a consumer in the same clock domain. Uses a write/read strobe handshake with EMPTY/FULL status flags.
- Read data is registered; storage is a flat register array that benches may probe hierarchically.

Parameters:
- DATA_WIDTH, 32, width of DIN, DOUT and each storage entry
- DEPTH, 8, number of entries (power of two)
- ADDR_WIDTH, 3, pointer width = log2(DEPTH)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- DIN  input  DATA_WIDTH  write data, sampled when WRITE accepted
- READ  input  1  read request strobe, level-sensitive per cycle
- WRITE  input  1  write request strobe, level-sensitive per cycle
- DOUT  output  DATA_WIDTH  registered read data
- EMPTY  output  1  high when the FIFO holds 0 entries
- FULL  output  1  high when the FIFO holds DEPTH entries

Positional port order is CLK, RESET, DIN, READ, WRITE, DOUT, EMPTY, FULL.

Behaviour:
- Reset (RESET=1 at a rising edge) has priority over everything. It sets:
  - write pointer = 0, read pointer = 0, count = 0
  - DOUT = 0
  - every fifo_mem entry = 0
  - EMPTY = 1, FULL = 0
- Storage:
  - Register array named fifo_mem, indices 0..DEPTH-1.
  - Entry k holds the k-th write modulo DEPTH after reset; the first write after reset lands in fifo_mem[0].
- Write accept: WRITE=1 and (FULL=0 or READ accepted in the same cycle).
  - On accept: fifo_mem[wr_ptr] <= DIN, and wr_ptr increments, wrapping from DEPTH-1 to 0.
- Write when FULL=1 with no accepted read is ignored. Memory, pointers and flags are unchanged; no error flag.
- Read accept: READ=1 and EMPTY=0.
  - On accept: DOUT <= fifo_mem[rd_ptr], and rd_ptr increments with wrap.
  - Read latency is 1 cycle: data appears on DOUT after the accepting edge.
- Read when EMPTY=1 is ignored, and DOUT holds its previous value. There is no write-to-read bypass: a write into an empty FIFO is readable from the following cycle.
- DOUT holds its last value whenever no read is accepted.
- Count update per edge:
  - write only: +1
  - read only: -1
  - both: unchanged
  - neither: unchanged
- Simultaneous READ and WRITE:
  - When neither full nor empty: both are performed, count unchanged.
  - When full: the read frees a slot and the write proceeds; FULL stays 1.
  - When empty: only the write is performed; EMPTY falls.
- Flags are registered and derived from the post-update count: EMPTY = (count==0), FULL = (count==DEPTH). EMPTY and FULL are never both 1.
- Pointers wrap naturally. Count is ADDR_WIDTH+1 bits wide to distinguish full from empty.
- DIN is only sampled on accepted writes; X on DIN with WRITE=0 has no effect.
- Reset asserted mid-operation discards all contents at that edge, regardless of READ/WRITE.

Test Plan:
- Reset: RESET=1 for one edge -> EMPTY=1, FULL=0, DOUT=0, fifo_mem[0..7]=0.
- Fill: write 0x11,0x22,…,0x88 on 8 consecutive edges -> fifo_mem[0]=0x11, fifo_mem[1]=0x22; EMPTY falls after 1st write; FULL=1 after 8th.
- Overflow: with FULL=1, WRITE=1 DIN=0xDEADBEEF, READ=0 -> memory unchanged, FULL stays 1. A subsequent 8 reads return 0x11…0x88 in order.
- Underflow: from empty, READ=1 for 3 cycles -> DOUT holds prior value, EMPTY stays 1, pointers unchanged.
- Simultaneous: hold READ=1 and WRITE=1 with 3 entries present, pushing 0xA0,0xA1,… -> count stays 3, DOUT streams oldest-first. At FULL, simultaneous read+write keeps FULL=1 with data order preserved across pointer wrap.
- Mid-op reset: 5 entries stored, RESET=1 with WRITE=1 -> EMPTY=1, DOUT=0, written data discarded.

Source files
------------

// File: rtl/fifo_memory.sv
// Single-clock 32x8 FIFO with registered read data and flags.
// Ports: CLK, RESET(sync high), DIN, READ, WRITE -> DOUT, EMPTY, FULL.
module fifo_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  READ,
  input  logic                  WRITE,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  EMPTY,
  output logic                  FULL
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  rd_ok;
  logic                  wr_ok;

  assign rd_ok = READ & ~EMPTY;
  // A read in the same cycle frees a slot,
  // so a full FIFO still accepts the write.
  assign wr_ok = WRITE & (~FULL | rd_ok);

  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      DOUT   <= '0;
      EMPTY  <= 1'b1;
      FULL   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        fifo_mem[wr_ptr] <= DIN;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        DOUT   <= fifo_mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      EMPTY <= (count_nxt == '0);
      FULL  <= (count_nxt == CNT_FULL);
    end
  end

endmodule

// File: tb/tb_fifo_memory.sv
// Bench for fifo_memory: directed + random stimulus
// against a queue-based reference model.
module tb_fifo_memory;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] DIN;
  logic        READ;
  logic        WRITE;
  logic [31:0] DOUT;
  logic        EMPTY;
  logic        FULL;

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  logic [31:0] m_dout;
  logic [31:0] m_mem [8];
  int          m_wn;

  fifo_memory dut (
    .CLK   (CLK),
    .RESET (RESET),
    .DIN   (DIN),
    .READ  (READ),
    .WRITE (WRITE),
    .DOUT  (DOUT),
    .EMPTY (EMPTY),
    .FULL  (FULL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic w,
                       input logic rd,
                       input logic [31:0] d);
    bit rok, wok;
    if (r) begin
      q.delete();
      m_dout = '0;
      m_wn = 0;
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
    end else begin
      rok = rd && (q.size() > 0);
      wok = w && (q.size() < 8 || rok);
      if (rok) m_dout = q.pop_front();
      if (wok) begin
        q.push_back(d);
        m_mem[m_wn % 8] = d;
        m_wn++;
      end
    end
  endtask

  task automatic compare_all();
    int bad;
    chk("dout", DOUT, m_dout);
    chk("empty", 32'(EMPTY), 32'(q.size() == 0));
    chk("full", 32'(FULL), 32'(q.size() == 8));
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (dut.fifo_mem[i] !== m_mem[i] && bad < 0)
        bad = i;
    if (bad >= 0)
      chk($sformatf("mem[%0d]", bad),
          dut.fifo_mem[bad], m_mem[bad]);
    else
      chk("mem", 32'd0, 32'(bad + 1));
  endtask

  task automatic step(input logic r, input logic w,
                      input logic rd,
                      input logic [31:0] d);
    RESET = r;
    WRITE = w;
    READ  = rd;
    DIN   = d;
    @(posedge CLK);
    model(r, w, rd, d);
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    RESET = 1'b1;
    WRITE = 1'b0;
    READ  = 1'b0;
    DIN   = '0;
    m_dout = '0;
    m_wn = 0;

    step(1, 0, 0, 32'h0);
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_full", 32'(FULL), 32'd0);
    chk("rst_dout", DOUT, 32'd0);
    chk("rst_mem7", dut.fifo_mem[7], 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 32'h11 * (i + 1));
      if (i == 0)
        chk("fill_empty_fall", 32'(EMPTY), 32'd0);
    end
    chk("fill_full", 32'(FULL), 32'd1);
    chk("fill_mem0", dut.fifo_mem[0], 32'h11);
    chk("fill_mem1", dut.fifo_mem[1], 32'h22);

    step(0, 1, 0, 32'hDEADBEEF);
    chk("ovf_full", 32'(FULL), 32'd1);
    chk("ovf_mem0", dut.fifo_mem[0], 32'h11);

    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, $urandom);
      chk("drain_dout", DOUT, 32'h11 * (i + 1));
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, $urandom);
      chk("udf_dout", DOUT, 32'h88);
      chk("udf_empty", 32'(EMPTY), 32'd1);
    end

    step(0, 1, 1, 32'h31);
    chk("wr_empty_nobypass", DOUT, 32'h88);
    step(0, 1, 0, 32'h32);
    step(0, 1, 0, 32'h33);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 32'hA0 + i);
      if (i == 0) chk("sim_first", DOUT, 32'h31);
      if (i == 3) chk("sim_fourth", DOUT, 32'hA0);
    end

    step(1, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 32'hB0 + i);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 32'hC0 + i);
      chk("simfull_flag", 32'(FULL), 32'd1);
      if (i == 0) chk("simfull_first", DOUT, 32'hB0);
    end
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, $urandom);
    chk("wrap_last", DOUT, 32'hC5);

    step(1, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 32'h50 + i);
    step(1, 1, 0, 32'h55);
    chk("midrst_empty", 32'(EMPTY), 32'd1);
    chk("midrst_dout", DOUT, 32'd0);
    chk("midrst_mem0", dut.fifo_mem[0], 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0),
           ($urandom_range(2) != 0),
           ($urandom_range(2) != 0),
           $urandom);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
